mc_datapath_p: RTL and testbench

MC_DATAPATH_P -- requirements
Module: mc_datapath_p

---
 rtl/mc_datapath_p.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_mc_datapath_p.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_p.sv
// Multi-cycle MIPS-style datapath with a register file, ALU, memory handshake FSM
// (with timeout), overflow trap with EPC capture, and exception return.
module mc_datapath_p #(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0080,
    parameter int          TMO      = 16
) (
    input  logic        clk,
    input  logic        reset,
    // controller inputs
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic [1:0]  RegDst,
    input  logic        RegWrite,
    input  logic [1:0]  MemtoReg,
    input  logic        ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  PCSource,
    input  logic        PCWrite,
    input  logic [1:0]  Branch,
    input  logic [2:0]  ALU_operation,
    input  logic        SorZ,
    input  logic        MemReq,
    input  logic        TrapEn,
    // memory side
    input  logic        MIO_ready,
    input  logic [31:0] data2CPU,
    // outputs
    output logic        M_req,
    output logic [31:0] M_addr,
    output logic [31:0] data_out,
    output logic [31:0] PC_Current,
    output logic [31:0] Inst,
    output logic [31:0] EPC,
    output logic        zero,
    output logic        overflow,
    output logic        stall,
    output logic        trap,
    output logic        mem_err
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Last wait-counter value tolerated before declaring a memory error.
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } mstate_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [31:0] pc_q,     pc_d;
    logic [31:0] ir_q,     ir_d;
    logic [31:0] dr_q,     dr_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] epc_q,    epc_d;
    mstate_t     state_q,  state_d;
    logic [7:0]  wcnt_q,   wcnt_d;
    logic        trap_q,   trap_d;
    logic        mem_err_q, mem_err_d;

    // ------------------------------------------------------------------
    // Internal combinational nets
    // ------------------------------------------------------------------
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] ext;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [31:0] alu_sum;
    logic [31:0] alu_diff;
    logic        alu_ovf;
    logic        mem_done;
    logic        stall_int;
    logic        trap_fire;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rd [32];

    // ------------------------------------------------------------------
    // Register file: one flop word per implemented register; index 0 and
    // indices at or above NREG have no storage and read as zero.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rf
            if (gi == 0 || gi >= NREG) begin : g_zero
                assign rf_rd[gi] = 32'h0;
            end else begin : g_reg
                logic [31:0] r_q, r_d;

                // Next value: take the write data when this word is addressed.
                always_comb begin
                    r_d = r_q;
                    if (rf_we && (rf_waddr == 5'(gi))) begin
                        r_d = rf_wdata;
                    end
                end

                // Register word storage with synchronous clear.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_q <= 32'h0;
                    end else begin
                        r_q <= r_d;
                    end
                end

                assign rf_rd[gi] = r_q;
            end
        end
    endgenerate

    // No write-through: reads always see the stored value.
    assign rs_data = rf_rd[ir_q[25:21]];
    assign rt_data = rf_rd[ir_q[20:16]];

    // ------------------------------------------------------------------
    // Operand selection and immediate extension.
    // ------------------------------------------------------------------
    always_comb begin
        ext   = SorZ ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'h0, ir_q[15:0]};
        alu_a = ALUSrcA ? rs_data : pc_q;
        alu_b = rt_data;
        case (ALUSrcB)
            2'b00:   alu_b = rt_data;
            2'b01:   alu_b = 32'd4;
            2'b10:   alu_b = ext;
            default: alu_b = {ext[29:0], 2'b00};
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: result, zero flag and signed overflow (ADD/SUB only).
    // ------------------------------------------------------------------
    always_comb begin
        alu_sum  = alu_a + alu_b;
        alu_diff = alu_a - alu_b;
        alu_res  = 32'h0;
        alu_ovf  = 1'b0;
        case (ALU_operation)
            OP_AND: alu_res = alu_a & alu_b;
            OP_OR:  alu_res = alu_a | alu_b;
            OP_ADD: begin
                alu_res = alu_sum;
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            OP_XOR: alu_res = alu_a ^ alu_b;
            OP_NOR: alu_res = ~(alu_a | alu_b);
            OP_SRL: alu_res = alu_b >> alu_a[4:0];
            OP_SUB: begin
                alu_res = alu_diff;
                alu_ovf = (alu_a[31] != alu_b[31]) && (alu_diff[31] != alu_a[31]);
            end
            OP_SLT: alu_res = {31'h0, $signed(alu_a) < $signed(alu_b)};
            default: alu_res = 32'h0;
        endcase
    end

    assign zero     = (alu_res == 32'h0);
    assign overflow = alu_ovf;

    // ------------------------------------------------------------------
    // Memory handshake: completion, stall and next FSM state.
    // ERR is a dead end that keeps the core frozen until reset.
    // ------------------------------------------------------------------
    always_comb begin
        mem_done  = 1'b0;
        stall_int = 1'b0;
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (MemReq) begin
                    if (MIO_ready) begin
                        mem_done = 1'b1;
                    end else begin
                        stall_int = 1'b1;
                        state_d   = S_WAIT;
                        wcnt_d    = 8'h0;
                    end
                end
            end
            S_WAIT: begin
                stall_int = 1'b1;
                if (MIO_ready) begin
                    mem_done = 1'b1;
                    state_d  = S_IDLE;
                end else if (wcnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wcnt_d = wcnt_q + 8'h1;
                end
            end
            default: begin
                stall_int = 1'b1;
            end
        endcase
        mem_err_d = mem_err_q || (state_d == S_ERR);
    end

    // M_req tracks MemReq directly while reset is held.
    always_comb begin
        if (reset) begin
            M_req = MemReq;
        end else begin
            M_req = (state_q == S_WAIT) || ((state_q == S_IDLE) && MemReq);
        end
    end

    assign stall = stall_int;

    // ------------------------------------------------------------------
    // PC, EPC, trap and register-file write control.
    // A trap overrides any PCWrite/branch request in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        trap_fire = TrapEn && alu_ovf && !stall_int;
        pc_en     = !stall_int &&
                    (PCWrite || (Branch[0] && zero) || (Branch[1] && !zero));
        case (PCSource)
            2'b00:   pc_next = alu_res;
            2'b01:   pc_next = aluout_q;
            2'b10:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
            default: pc_next = epc_q;
        endcase

        pc_d  = pc_q;
        epc_d = epc_q;
        if (trap_fire) begin
            pc_d  = TRAP_VEC;
            epc_d = pc_q;
        end else if (pc_en) begin
            pc_d = pc_next;
        end

        trap_d = trap_q;
        if (trap_fire) begin
            trap_d = 1'b1;
        end else if ((PCSource == 2'b11) && PCWrite && !stall_int) begin
            trap_d = 1'b0;
        end

        rf_we = RegWrite && !stall_int && !trap_fire;
        case (RegDst)
            2'b00:   rf_waddr = ir_q[20:16];
            2'b01:   rf_waddr = ir_q[15:11];
            2'b10:   rf_waddr = 5'd31;
            default: rf_waddr = 5'd0;
        endcase
        case (MemtoReg)
            2'b00:   rf_wdata = aluout_q;
            2'b01:   rf_wdata = dr_q;
            2'b10:   rf_wdata = {ir_q[15:0], 16'h0};
            default: rf_wdata = pc_q;
        endcase
    end

    // IR/DR capture on access completion, ALUOut refresh unless stalled.
    always_comb begin
        ir_d     = (mem_done && IRWrite) ? data2CPU : ir_q;
        dr_d     = mem_done ? data2CPU : dr_q;
        aluout_d = stall_int ? aluout_q : alu_res;
    end

    // All datapath and control state, reset first.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            dr_q      <= 32'h0;
            aluout_q  <= 32'h0;
            epc_q     <= 32'h0;
            state_q   <= S_IDLE;
            wcnt_q    <= 8'h0;
            trap_q    <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            dr_q      <= dr_d;
            aluout_q  <= aluout_d;
            epc_q     <= epc_d;
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            trap_q    <= trap_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign M_addr     = IorD ? aluout_q : pc_q;
    assign data_out   = rt_data;
    assign PC_Current = pc_q;
    assign Inst       = ir_q;
    assign EPC        = epc_q;
    assign trap       = trap_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mc_datapath_p.sv
// Scoreboard bench for mc_datapath_p: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_mc_datapath_p;

    localparam int TMO_P = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, SorZ, MemReq, TrapEn;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource, Branch;
    logic [2:0]  ALU_operation;
    logic        MIO_ready;
    logic [31:0] data2CPU;
    logic        M_req, zero, overflow, stall, trap, mem_err;
    logic [31:0] M_addr, data_out, PC_Current, Inst, EPC;

    mc_datapath_p #(
        .NREG(8), .RESET_PC(32'h0), .TRAP_VEC(32'h80), .TMO(TMO_P)
    ) dut (
        .clk(clk), .reset(reset),
        .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .PCWrite(PCWrite), .Branch(Branch),
        .ALU_operation(ALU_operation), .SorZ(SorZ), .MemReq(MemReq), .TrapEn(TrapEn),
        .MIO_ready(MIO_ready), .data2CPU(data2CPU),
        .M_req(M_req), .M_addr(M_addr), .data_out(data_out), .PC_Current(PC_Current),
        .Inst(Inst), .EPC(EPC), .zero(zero), .overflow(overflow), .stall(stall),
        .trap(trap), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_PC, S_IR, S_EPC, S_DOUT, S_STALL, S_MREQ, S_MADDR, S_MERR, S_TRAP, S_ZERO, S_OVF
    } sig_e;

    typedef struct {
        int          at;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual_of(input sig_e s);
        case (s)
            S_PC:    return PC_Current;
            S_IR:    return Inst;
            S_EPC:   return EPC;
            S_DOUT:  return data_out;
            S_STALL: return {31'h0, stall};
            S_MREQ:  return {31'h0, M_req};
            S_MADDR: return M_addr;
            S_MERR:  return {31'h0, mem_err};
            S_TRAP:  return {31'h0, trap};
            S_ZERO:  return {31'h0, zero};
            default: return {31'h0, overflow};
        endcase
    endfunction

    // Monitor: every negedge, compare all expectations due by this cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].at <= cyc) begin
                e   = sbq.pop_front();
                act = actual_of(e.sig);
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
                end else begin
                    $display("ok   %s: %h (cycle %0d)", e.name, act, cyc);
                end
            end
        end
    end

    task automatic chk(input sig_e s, input logic [31:0] v, input string n);
        exp_t e;
        e.at = cyc; e.sig = s; e.val = v; e.name = n;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_ctl();
        IorD = 0; IRWrite = 0; RegDst = 0; RegWrite = 0; MemtoReg = 0;
        ALUSrcA = 0; ALUSrcB = 0; PCSource = 0; PCWrite = 0; Branch = 0;
        ALU_operation = 0; SorZ = 0; MemReq = 0; TrapEn = 0;
    endtask

    // Single-cycle memory access that completes immediately.
    task automatic fetch(input logic [31:0] d, input logic irw);
        idle_ctl();
        MemReq = 1; MIO_ready = 1; IRWrite = irw; data2CPU = d;
        step();
        idle_ctl();
        MIO_ready = 0;
    endtask

    // Write val to register r through DR (rt destination), then read back via rt.
    task automatic wreg(input logic [4:0] r, input logic [31:0] val,
                        input logic [31:0] old_v, input logic [31:0] new_v, input string n);
        fetch({11'h0, r, 16'h0}, 1'b1);
        fetch(val, 1'b0);
        RegWrite = 1; RegDst = 2'b00; MemtoReg = 2'b01;
        chk(S_DOUT, old_v, {n, "_before"});
        step();
        idle_ctl();
        chk(S_DOUT, new_v, {n, "_after"});
        step();
    endtask

    task automatic rdreg(input logic [4:0] r, input logic [31:0] v, input string n);
        fetch({11'h0, r, 16'h0}, 1'b1);
        chk(S_DOUT, v, n);
        step();
    endtask

    // ALU table: operand B select, SorZ, operation, expected result.
    // Operands: rs = r5 = DEADBEEF, rt = r3 = 1, imm = 8000.
    logic [1:0]  t_srcb [9] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11};
    logic        t_sorz [9] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    logic [2:0]  t_op   [9] = '{3'b000, 3'b000, 3'b001, 3'b110, 3'b111, 3'b100, 3'b011, 3'b101, 3'b010};
    logic [31:0] t_res  [9] = '{32'hDEAD_8000, 32'h0000_8000, 32'hFFFF_BEEF, 32'hDEAD_BEEE,
                                32'h0000_0001, 32'h2152_4110, 32'hDEAD_BEEE, 32'h0001_FFFF,
                                32'hDEAB_BEEF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; idle_ctl(); MIO_ready = 0; data2CPU = 0;
        step(); step();
        chk(S_PC, 32'h0, "rst_pc");   chk(S_IR, 32'h0, "rst_ir");
        chk(S_EPC, 32'h0, "rst_epc"); chk(S_TRAP, 0, "rst_trap");
        chk(S_MERR, 0, "rst_merr");   chk(S_STALL, 0, "rst_stall");
        chk(S_MREQ, 0, "rst_mreq0");
        step();
        // M_req follows MemReq during reset, nothing loads
        MemReq = 1; MIO_ready = 1; data2CPU = 32'hFFFF_FFFF; IRWrite = 1;
        PCWrite = 1; ALUSrcB = 2'b01; ALU_operation = 3'b010;
        chk(S_MREQ, 1, "rst_mreq1");
        step();
        idle_ctl(); MIO_ready = 0;
        chk(S_IR, 32'h0, "rst_ir_hold"); chk(S_PC, 32'h0, "rst_pc_hold");
        reset = 0;
        step();

        // Instruction fetch with PC+4
        MemReq = 1; IRWrite = 1; MIO_ready = 1; data2CPU = 32'h2008_0005;
        PCWrite = 1; ALUSrcA = 0; ALUSrcB = 2'b01; ALU_operation = 3'b010;
        chk(S_STALL, 0, "f_stall"); chk(S_MREQ, 1, "f_mreq"); chk(S_MADDR, 32'h0, "f_maddr");
        step();
        idle_ctl(); MIO_ready = 0;
        chk(S_IR, 32'h2008_0005, "f_ir"); chk(S_PC, 32'h4, "f_pc"); chk(S_STALL, 0, "f_stall2");
        step();

        // Register file with NREG=8
        wreg(5'd5,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, "r5");
        wreg(5'd12, 32'hDEAD_BEEF, 32'h0, 32'h0,         "r12");
        rdreg(5'd4, 32'h0, "r4_no_alias");
        wreg(5'd0,  32'hDEAD_BEEF, 32'h0, 32'h0,         "r0");
        rdreg(5'd5, 32'hDEAD_BEEF, "r5_keep");

        // Overflow trap and exception return
        wreg(5'd2, 32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, "r2");
        wreg(5'd3, 32'h0000_0001, 32'h0, 32'h0000_0001, "r3");
        wreg(5'd4, 32'h0000_1234, 32'h0, 32'h0000_1234, "r4");
        fetch(32'h0000_0010, 1'b1);
        PCSource = 2'b10; PCWrite = 1;
        step();
        idle_ctl();
        chk(S_PC, 32'h40, "jmp_pc");
        fetch(32'h0043_2000, 1'b1);           // rs=2 rt=3 rd=4
        ALUSrcA = 1; ALUSrcB = 2'b00; ALU_operation = 3'b010; TrapEn = 1;
        RegWrite = 1; RegDst = 2'b01; MemtoReg = 2'b01; PCWrite = 1; PCSource = 2'b00;
        chk(S_OVF, 1, "trap_ovf"); chk(S_STALL, 0, "trap_stall");
        step();
        idle_ctl();
        chk(S_EPC, 32'h40, "trap_epc"); chk(S_PC, 32'h80, "trap_pc"); chk(S_TRAP, 1, "trap_set");
        step();
        PCSource = 2'b11; PCWrite = 1;
        chk(S_TRAP, 1, "trap_sticky");
        step();
        idle_ctl();
        chk(S_PC, 32'h40, "eret_pc"); chk(S_TRAP, 0, "eret_trap");
        step();
        rdreg(5'd4, 32'h0000_1234, "trap_rd_keep");

        // Branches: rs==rt==r5, imm=4
        fetch(32'h00A5_0004, 1'b1);
        ALUSrcA = 0; ALUSrcB = 2'b11; SorZ = 1; ALU_operation = 3'b010;
        step();
        idle_ctl();
        ALUSrcA = 1; ALUSrcB = 2'b00; ALU_operation = 3'b110; Branch = 2'b01; PCSource = 2'b01;
        chk(S_ZERO, 1, "beq_zero");
        step();
        idle_ctl();
        chk(S_PC, 32'h50, "beq_pc");
        ALUSrcA = 1; ALUSrcB = 2'b00; ALU_operation = 3'b110; Branch = 2'b10; PCSource = 2'b01;
        chk(S_ZERO, 1, "bne_zero");
        step();
        idle_ctl();
        chk(S_PC, 32'h50, "bne_hold");
        ALUSrcA = 1; ALUSrcB = 2'b00; ALU_operation = 3'b010; Branch = 2'b10; PCSource = 2'b00;
        chk(S_ZERO, 0, "bne2_zero"); chk(S_OVF, 0, "bne2_ovf");
        step();
        idle_ctl();
        chk(S_PC, 32'hBD5B_7DDE, "bne2_pc");
        step();

        // ALU operations observed through ALUOut on M_addr
        fetch(32'h00A3_8000, 1'b1);           // rs=5 rt=3 imm=8000
        for (int i = 0; i < 9; i++) begin
            idle_ctl();
            ALUSrcA = 1; ALUSrcB = t_srcb[i]; SorZ = t_sorz[i]; ALU_operation = t_op[i];
            chk(S_ZERO, 0, $sformatf("alu%0d_zero", i));
            chk(S_OVF,  0, $sformatf("alu%0d_ovf", i));
            step();
            idle_ctl(); IorD = 1;
            chk(S_MADDR, t_res[i], $sformatf("alu%0d_res", i));
            step();
        end
        idle_ctl();

        // Wait states: ready low two cycles, high on the third
        MemReq = 1; IRWrite = 1; data2CPU = 32'hAABB_CCDD; MIO_ready = 0;
        PCWrite = 1; ALUSrcB = 2'b01; ALU_operation = 3'b010;
        chk(S_STALL, 1, "w1_stall"); chk(S_MREQ, 1, "w1_mreq"); chk(S_MADDR, 32'hBD5B_7DDE, "w1_maddr");
        step();
        chk(S_STALL, 1, "w2_stall"); chk(S_IR, 32'h00A3_8000, "w2_ir"); chk(S_PC, 32'hBD5B_7DDE, "w2_pc");
        step();
        MIO_ready = 1;
        chk(S_STALL, 1, "w3_stall"); chk(S_IR, 32'h00A3_8000, "w3_ir"); chk(S_MREQ, 1, "w3_mreq");
        step();
        idle_ctl(); MIO_ready = 0;
        chk(S_IR, 32'hAABB_CCDD, "w4_ir"); chk(S_PC, 32'hBD5B_7DDE, "w4_pc");
        chk(S_STALL, 0, "w4_stall"); chk(S_MREQ, 0, "w4_mreq");
        step();

        // Timeout into the error state
        MemReq = 1; IRWrite = 1; data2CPU = 32'h1111_2222; MIO_ready = 0;
        for (int i = 0; i < TMO_P; i++) begin
            chk(S_STALL, 1, $sformatf("tmo%0d_stall", i));
            chk(S_MERR,  0, $sformatf("tmo%0d_merr", i));
            chk(S_MREQ,  1, $sformatf("tmo%0d_mreq", i));
            step();
        end
        chk(S_STALL, 1, "tmo_last_stall");
        step();
        chk(S_MERR, 1, "err_merr"); chk(S_STALL, 1, "err_stall"); chk(S_MREQ, 0, "err_mreq");
        MIO_ready = 1;
        step();
        MIO_ready = 0;
        chk(S_IR, 32'hAABB_CCDD, "err_ir_hold"); chk(S_MERR, 1, "err_sticky"); chk(S_STALL, 1, "err_stall2");
        step();
        idle_ctl(); reset = 1;
        step();
        reset = 0;
        chk(S_MERR, 0, "rst2_merr"); chk(S_STALL, 0, "rst2_stall");
        chk(S_PC, 32'h0, "rst2_pc"); chk(S_IR, 32'h0, "rst2_ir");
        step();
        step();

        if (sbq.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sbq.size());
            errors += sbq.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
